ram_responder: RTL and testbench
================================

RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, word-address bits; memory holds 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0, byte address of word 0.
REQ-003 Parameter WAIT_CYCLES, default 0, extra wait states per access, range 0..15.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_b  input  1  asynchronous reset, active low.
REQ-006 req  input  1  request valid from initiator.
REQ-007 write  input  1  1 = write, 0 = read.
REQ-008 wstrb  input  4  byte-lane write enables; bit i enables wdata[8i+7:8i].
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  32  write data.
REQ-011 ready  output  1  responder can accept a request this cycle.
REQ-012 rvalid  output  1  read data valid, one-cycle pulse per accepted read.
REQ-013 rdata  output  32  read data, meaningful only while rvalid=1.
REQ-014 err  output  1  one-cycle pulse, accepted access was out of range.

Function
REQ-015 Request SHALL be accepted on a rising edge where req=1 and ready=1; req while ready=0 is ignored, with no side effect.
REQ-016 State machine SHALL have states IDLE and WAIT; ready=1 in IDLE only.
REQ-017 WAIT_CYCLES=0: state SHALL stay IDLE; ready constantly 1; one request accepted per cycle.
REQ-018 WAIT_CYCLES=N>0: acceptance in IDLE at edge T SHALL load a counter with N and enter WAIT; ready=0 for cycles T+1..T+N; counter decrements each cycle; at count 1 return to IDLE so ready=1 in cycle T+N+1.
REQ-019 Access SHALL be performed at the edge ending the last wait cycle (edge T for N=0, edge T+N otherwise); addr/write/wstrb/wdata are captured at acceptance and held internally.
REQ-020 Read accepted at edge T SHALL produce rvalid=1 with rdata in cycle T+1+N only; rvalid=0 otherwise.
REQ-021 Writes SHALL update only byte lanes with wstrb=1; wstrb=0 write performs no update but completes normally; writes produce no rvalid.
REQ-022 Word index SHALL be (addr-BASE_ADDR)[ADDR_WIDTH+1:2]; addr[1:0] ignored (word access; initiator handles byte alignment).
REQ-023 In range iff BASE_ADDR <= addr < BASE_ADDR + 4*2^ADDR_WIDTH, using 33-bit unsigned compare; out-of-range read SHALL return rdata=0 with rvalid; out-of-range write SHALL be dropped; both pulse err in the same cycle a read's rvalid would appear.
REQ-024 Read accepted the cycle after a write to the same word SHALL return the newly written data (write completes before the later read samples).
REQ-025 Back-to-back reads with N=0 SHALL give rvalid in consecutive cycles, in request order.
REQ-026 Memory contents SHALL NOT be reset and are undefined until written.

Reset
REQ-027 While rst_b=0: state IDLE, counter 0, ready=1, rvalid=0, rdata=0, err=0, captured request cleared.
REQ-028 Reset asserted during WAIT SHALL abort the access: pending write not applied, pending read produces no rvalid.
REQ-029 First request SHALL be accepted on the first rising edge after rst_b deasserts.

Verification
REQ-030 N=0: write 0xDEADBEEF to 0x0010 wstrb=4'hF, read 0x0010 next cycle -> rvalid one cycle after read accept, rdata=0xDEADBEEF.
REQ-031 N=0: write 0x0000AA00 wstrb=4'b0010 over 0x11223344 -> read returns 0x1122AA44.
REQ-032 N=3: read accepted edge T -> ready=0 cycles T+1..T+3, rvalid=1 only cycle T+4, ready=1 cycle T+4; req held during wait not double-accepted.
REQ-033 ADDR_WIDTH=12, BASE_ADDR=0: read 0x4000 -> rvalid=1, rdata=0, err=1; write 0x4000 then read 0x0000 -> word 0 unchanged.
REQ-034 N=3: write 0x12345678 to 0x0020 (word previously 0), assert rst_b=0 at T+2 -> ready=1, rvalid=0; later read 0x0020 returns 0.
REQ-035 N=0: four back-to-back reads of 0x0,0x4,0x8,0xC preloaded 1..4 -> rvalid four consecutive cycles, rdata 1,2,3,4.

Source files
------------

// File: rtl/ram_responder.sv
// Single-port word RAM slave with a fixed number of wait states per access.
// Out-of-range accesses complete normally but pulse err and never touch memory.
module ram_responder #(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req,
  input  logic        write,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int          DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_N = 4'(WAIT_CYCLES);
  localparam logic [32:0] LIMIT  = {1'b0, BASE_ADDR} + (33'd4 << ADDR_WIDTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t                  state_r;
  logic [3:0]              cnt_r;
  logic                    cap_write_r;
  logic [3:0]              cap_wstrb_r;
  logic [31:0]             cap_addr_r;
  logic [31:0]             cap_wdata_r;
  logic                    ready_r;
  logic                    rvalid_r;
  logic [31:0]             rdata_r;
  logic                    err_r;
  logic [31:0]             mem_r [DEPTH];

  logic                    accept_s;
  logic                    do_access_s;
  logic                    acc_write_s;
  logic [3:0]              acc_wstrb_s;
  logic [31:0]             acc_addr_s;
  logic [31:0]             acc_wdata_s;
  logic [31:0]             offset_s;
  logic [ADDR_WIDTH-1:0]   idx_s;
  logic                    in_range_s;
  logic                    mem_we_s;

  // Access decode: with no wait states the live request is used, otherwise the captured one.
  always_comb begin
    accept_s    = req && (state_r == ST_IDLE);
    acc_write_s = 1'b0;
    acc_wstrb_s = 4'h0;
    acc_addr_s  = 32'h0000_0000;
    acc_wdata_s = 32'h0000_0000;
    if (state_r == ST_IDLE) begin
      acc_write_s = write;
      acc_wstrb_s = wstrb;
      acc_addr_s  = addr;
      acc_wdata_s = wdata;
    end else begin
      acc_write_s = cap_write_r;
      acc_wstrb_s = cap_wstrb_r;
      acc_addr_s  = cap_addr_r;
      acc_wdata_s = cap_wdata_r;
    end
    if (WAIT_N == 4'd0) begin
      do_access_s = accept_s;
    end else begin
      do_access_s = (state_r == ST_WAIT) && (cnt_r == 4'd1);
    end
    offset_s   = acc_addr_s - BASE_ADDR;
    idx_s      = ADDR_WIDTH'(offset_s >> 2);
    in_range_s = ({1'b0, acc_addr_s} >= {1'b0, BASE_ADDR}) && ({1'b0, acc_addr_s} < LIMIT);
    mem_we_s   = rst_b && do_access_s && acc_write_s && in_range_s;
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      cap_write_r <= 1'b0;
      cap_wstrb_r <= 4'h0;
      cap_addr_r  <= 32'h0000_0000;
      cap_wdata_r <= 32'h0000_0000;
      ready_r     <= 1'b1;
      rvalid_r    <= 1'b0;
      rdata_r     <= 32'h0000_0000;
      err_r       <= 1'b0;
    end else begin
      rvalid_r <= do_access_s && !acc_write_s;
      err_r    <= do_access_s && !in_range_s;
      if (do_access_s && !acc_write_s && in_range_s) begin
        rdata_r <= mem_r[idx_s];
      end else begin
        rdata_r <= 32'h0000_0000;
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s && (WAIT_N != 4'd0)) begin
            state_r     <= ST_WAIT;
            cnt_r       <= WAIT_N;
            ready_r     <= 1'b0;
            cap_write_r <= write;
            cap_wstrb_r <= wstrb;
            cap_addr_r  <= addr;
            cap_wdata_r <= wdata;
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_r == 4'd1) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            ready_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Byte-lane memory write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wstrb_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= acc_wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign ready  = ready_r;
  assign rvalid = rvalid_r;
  assign rdata  = rdata_r;
  assign err    = err_r;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: a zero-wait instance (vector table, back-to-back and random
// traffic against a word-level model) and a three-wait-state instance (timing and reset abort).
module tb_ram_responder;

  logic        clk;
  logic        rst_b, rst3_b;
  logic        req0, write0, req3, write3;
  logic [3:0]  wstrb0, wstrb3;
  logic [31:0] addr0, wdata0, addr3, wdata3;
  logic        ready0, rvalid0, err0, ready3, rvalid3, err3;
  logic [31:0] rdata0, rdata3;

  int pass_cnt = 0;
  int total_cnt = 0;

  ram_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_b(rst_b), .req(req0), .write(write0), .wstrb(wstrb0), .addr(addr0),
    .wdata(wdata0), .ready(ready0), .rvalid(rvalid0), .rdata(rdata0), .err(err0));

  ram_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_b(rst3_b), .req(req3), .write(write3), .wstrb(wstrb3), .addr(addr3),
    .wdata(wdata3), .ready(ready3), .rvalid(rvalid3), .rdata(rdata3), .err(err3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Word-level reference memory keyed by word number (byte address / 4).
  logic [31:0] model [int];

  task automatic ref_access(input logic wr, input logic [3:0] st, input logic [31:0] a,
                            input logic [31:0] d, output logic rv, output logic [31:0] rd,
                            output logic er);
    longint unsigned ua;
    bit inr;
    int key;
    ua  = longint'(a);
    inr = (ua < 64'd16384);
    key = int'(a / 32'd4);
    rv  = !wr;
    er  = !inr;
    rd  = 32'h0;
    if (wr && inr) begin
      logic [31:0] w;
      w = model.exists(key) ? model[key] : 32'h0;
      for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = d[8*b +: 8];
      model[key] = w;
    end
    if (!wr && inr) rd = model[key];
  endtask

  // One access on the zero-wait instance; returns at the negedge where its response is visible.
  task automatic acc0(input logic wr, input logic [3:0] st, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req0 = 1'b1; write0 = wr; wstrb0 = st; addr0 = a; wdata0 = d;
    @(negedge clk);
    req0 = 1'b0;
  endtask

  // One access on the wait-state instance; waits (bounded) for ready to return.
  task automatic acc3(input logic wr, input logic [3:0] st, input logic [31:0] a, input logic [31:0] d,
                      output logic rv, output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    req3 = 1'b1; write3 = wr; wstrb3 = st; addr3 = a; wdata3 = d;
    @(negedge clk);
    req3 = 1'b0;
    n = 1;
    while (!ready3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("acc3_latency", n, 32'd4);
    rv = rvalid3; rd = rdata3; er = err3;
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  st;
    logic [31:0] a;
    logic [31:0] d;
    logic        rv;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic rv, er, p_req, p_rv, p_er;
    logic [31:0] rd, p_rd;
    logic [31:0] pool [9];

    vecs[0]  = '{1'b1, 4'hF,    32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 4'h0,    32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 4'hF,    32'h0000_0014, 32'h1122_3344, 1'b0, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 4'b0010, 32'h0000_0014, 32'h0000_AA00, 1'b0, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 4'h0,    32'h0000_0014, 32'h0,         1'b1, 32'h1122_AA44, 1'b0};
    vecs[5]  = '{1'b1, 4'hF,    32'h0000_0000, 32'hCAFE_0001, 1'b0, 32'h0,         1'b0};
    vecs[6]  = '{1'b0, 4'h0,    32'h0000_4000, 32'h0,         1'b1, 32'h0,         1'b1};
    vecs[7]  = '{1'b1, 4'hF,    32'h0000_4000, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1};
    vecs[8]  = '{1'b0, 4'h0,    32'h0000_0000, 32'h0,         1'b1, 32'hCAFE_0001, 1'b0};
    vecs[9]  = '{1'b1, 4'hF,    32'h0000_3FFC, 32'hA5A5_A5A5, 1'b0, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 4'h0,    32'h0000_3FFC, 32'h0,         1'b1, 32'hA5A5_A5A5, 1'b0};
    vecs[11] = '{1'b1, 4'h0,    32'h0000_0014, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 4'h0,    32'h0000_0014, 32'h0,         1'b1, 32'h1122_AA44, 1'b0};
    vecs[13] = '{1'b0, 4'h0,    32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0,         1'b1};
    vecs[14] = '{1'b0, 4'h0,    32'h0000_0017, 32'h0,         1'b1, 32'h1122_AA44, 1'b0};

    rst_b = 1'b0; rst3_b = 1'b0;
    req0 = 1'b0; write0 = 1'b0; wstrb0 = 4'h0; addr0 = 32'h0; wdata0 = 32'h0;
    req3 = 1'b0; write3 = 1'b0; wstrb3 = 4'h0; addr3 = 32'h0; wdata3 = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready0", {31'd0, ready0}, 32'd1);
    chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_err0", {31'd0, err0}, 32'd0);
    chk("rst_ready3", {31'd0, ready3}, 32'd1);
    chk("rst_rvalid3", {31'd0, rvalid3}, 32'd0);

    // Release reset with a request already pending: it must be taken on the very next edge.
    rst_b = 1'b1; rst3_b = 1'b1;
    req3 = 1'b1; write3 = 1'b1; wstrb3 = 4'hF; addr3 = 32'h20; wdata3 = 32'h0;
    @(negedge clk);
    req3 = 1'b0;
    chk("first_accept_ready3", {31'd0, ready3}, 32'd0);
    for (int n = 0; n < 40 && !ready3; n++) @(negedge clk);
    chk("first_accept_done3", {31'd0, ready3}, 32'd1);

    for (int i = 0; i < 15; i++) begin
      acc0(vecs[i].wr, vecs[i].st, vecs[i].a, vecs[i].d);
      chk($sformatf("vec%0d_ready", i), {31'd0, ready0}, 32'd1);
      chk($sformatf("vec%0d_rvalid", i), {31'd0, rvalid0}, {31'd0, vecs[i].rv});
      chk($sformatf("vec%0d_err", i), {31'd0, err0}, {31'd0, vecs[i].er});
      if (vecs[i].rv) chk($sformatf("vec%0d_rdata", i), rdata0, vecs[i].rd);
    end

    // Four back-to-back reads of preloaded words.
    for (int i = 0; i < 4; i++) acc0(1'b1, 4'hF, 32'(4 * i), 32'(i + 1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("b2b%0d_rvalid", i), {31'd0, rvalid0}, 32'd1);
        chk($sformatf("b2b%0d_rdata", i), rdata0, 32'(i));
      end
      if (i < 4) begin
        req0 = 1'b1; write0 = 1'b0; addr0 = 32'(4 * i);
      end else begin
        req0 = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_end_rvalid", {31'd0, rvalid0}, 32'd0);

    // Random traffic on the zero-wait instance against the word model.
    pool = '{32'h0, 32'h4, 32'h10, 32'h14, 32'h100, 32'h3FFC, 32'h4000, 32'hFFFF_FFFC, 32'h8000_0000};
    for (int i = 0; i < 6; i++) begin
      logic [31:0] v;
      v = $urandom;
      acc0(1'b1, 4'hF, pool[i], v);
      ref_access(1'b1, 4'hF, pool[i], v, rv, rd, er);
    end
    p_req = 1'b0; p_rv = 1'b0; p_er = 1'b0; p_rd = 32'h0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c > 0) begin
        chk("rnd_rvalid", {31'd0, rvalid0}, {31'd0, p_req && p_rv});
        chk("rnd_err", {31'd0, err0}, {31'd0, p_req && p_er});
        if (p_req && p_rv) chk("rnd_rdata", rdata0, p_rd);
      end
      p_req  = ($urandom_range(0, 3) != 0);
      req0   = p_req;
      write0 = $urandom_range(0, 1) == 1;
      wstrb0 = 4'($urandom);
      addr0  = pool[$urandom_range(0, 8)] | 32'($urandom_range(0, 3));
      wdata0 = $urandom;
      if (p_req) ref_access(write0, wstrb0, addr0, wdata0, p_rv, p_rd, p_er);
    end
    @(negedge clk);
    req0 = 1'b0;
    chk("rnd_last_rvalid", {31'd0, rvalid0}, {31'd0, p_req && p_rv});
    if (p_req && p_rv) chk("rnd_last_rdata", rdata0, p_rd);

    // Wait-state timing: held request must not be taken twice.
    acc3(1'b1, 4'hF, 32'h10, 32'h5A5A_0003, rv, rd, er);
    chk("w3_write_rvalid", {31'd0, rv}, 32'd0);
    @(negedge clk);
    req3 = 1'b1; write3 = 1'b0; addr3 = 32'h10;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("w3_ready_T%0d", k), {31'd0, ready3}, 32'd0);
      chk($sformatf("w3_rvalid_T%0d", k), {31'd0, rvalid3}, 32'd0);
    end
    @(negedge clk);
    req3 = 1'b0;
    chk("w3_ready_T4", {31'd0, ready3}, 32'd1);
    chk("w3_rvalid_T4", {31'd0, rvalid3}, 32'd1);
    chk("w3_rdata_T4", rdata3, 32'h5A5A_0003);
    for (int k = 5; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("w3_rvalid_T%0d", k), {31'd0, rvalid3}, 32'd0);
      chk($sformatf("w3_ready_T%0d", k), {31'd0, ready3}, 32'd1);
    end

    acc3(1'b0, 4'h0, 32'h4000, 32'h0, rv, rd, er);
    chk("w3_oor_rvalid", {31'd0, rv}, 32'd1);
    chk("w3_oor_err", {31'd0, er}, 32'd1);
    chk("w3_oor_rdata", rd, 32'h0);

    // Reset during the wait aborts the pending write.
    @(negedge clk);
    req3 = 1'b1; write3 = 1'b1; wstrb3 = 4'hF; addr3 = 32'h20; wdata3 = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req3 = 1'b0;
    @(negedge clk);
    rst3_b = 1'b0;
    #1;
    chk("abort_ready", {31'd0, ready3}, 32'd1);
    chk("abort_rvalid", {31'd0, rvalid3}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_rvalid_hold", {31'd0, rvalid3}, 32'd0);
    end
    rst3_b = 1'b1;
    acc3(1'b0, 4'h0, 32'h20, 32'h0, rv, rd, er);
    chk("abort_read_rvalid", {31'd0, rv}, 32'd1);
    chk("abort_read_rdata", rd, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
